// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the execute stage and a req/gnt/rvalid data memory.
// Handshake: a request sits on dmem_* while dmem_req_o=1 until the cycle dmem_gnt_i=1; a load then waits for one dmem_rvalid_i.
module load_store_unit #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    input  logic              ex_memren_i,
    input  logic              ex_memwren_i,
    input  logic [AWIDTH-1:0] ex_addr_i,
    input  logic [DWIDTH-1:0] ex_wdata_i,
    input  logic [2:0]        ex_funct3_i,
    output logic              lsu_stall_o,
    output logic              done_o,
    output logic              fault_o,
    output logic              wb_valid_o,
    output logic [DWIDTH-1:0] wb_data_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [AWIDTH-1:0] dmem_addr_o,
    output logic [DWIDTH-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DWIDTH-1:0] dmem_rdata_i,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] wb_data_q, wb_data_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic              wb_valid_q, wb_valid_d;

    logic              accept, misaligned, illegal, in_req;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DWIDTH-1:0] load_ext, st_data;
    logic [3:0]        be;

    // Gated with rst so every output, including the stall, reads 0 while reset is held.
    assign accept = rst && (state_q == IDLE) && ex_valid_i
                    && (ex_memren_i || ex_memwren_i) && !done_q;

    always_comb begin
        misaligned = 1'b0;
        case (ex_funct3_i[1:0])
            2'b01:   misaligned = ex_addr_i[0];
            2'b10:   misaligned = (ex_addr_i[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign illegal = ex_memwren_i ? (ex_funct3_i >= 3'b011)
                                  : ((ex_funct3_i == 3'b011) || (ex_funct3_i[2:1] == 2'b11));

    always_comb begin
        lane_b = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        lane_h = dmem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{(DWIDTH-8){lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{(DWIDTH-16){lane_h[15]}}, lane_h};
            3'b100:  load_ext = {{(DWIDTH-8){1'b0}}, lane_b};
            3'b101:  load_ext = {{(DWIDTH-16){1'b0}}, lane_h};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    // Stores replicate the datum across the word so the byte enables alone pick the lane.
    always_comb begin
        be      = 4'b0000;
        st_data = wdata_q;
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    be      = 4'b0001 << addr_q[1:0];
                    st_data = {(DWIDTH/8){wdata_q[7:0]}};
                end
                2'b01: begin
                    be      = 4'b0011 << addr_q[1:0];
                    st_data = {(DWIDTH/16){wdata_q[15:0]}};
                end
                default: be = 4'b1111;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        wb_data_d  = wb_data_q;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        wb_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = ex_addr_i;
                    wdata_d  = ex_wdata_i;
                    funct3_d = ex_funct3_i;
                    we_d     = ex_memwren_i;
                    if (misaligned || illegal) begin
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_data_d  = load_ext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_data_q  <= '0;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_data_q  <= wb_data_d;
            funct3_q   <= funct3_d;
            we_q       <= we_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign in_req       = (state_q == REQ);
    assign lsu_stall_o  = accept || in_req || (state_q == WAIT);
    assign done_o       = done_q;
    assign fault_o      = fault_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_data_o    = wb_data_q;
    assign dmem_req_o   = in_req;
    assign dmem_we_o    = in_req && we_q;
    assign dmem_be_o    = in_req ? be : 4'b0000;
    assign dmem_addr_o  = in_req ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
    assign dmem_wdata_o = (in_req && we_q) ? st_data : '0;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL take parameters: AWIDTH, 32, address width; DWIDTH, 32, data width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous reset, active-low (asserted at 0).
REQ-005 ex_valid_i  input  1  execute presents an instruction this cycle.
REQ-006 ex_memren_i / ex_memwren_i  input  1 each  load / store request.
REQ-007 ex_addr_i  input  AWIDTH  effective address (ALU result).
REQ-008 ex_wdata_i  input  DWIDTH  store data (rs2).
REQ-009 ex_funct3_i  input  3  access size/sign.
REQ-010 lsu_stall_o  output  1  upstream holds its instruction.
REQ-011 done_o / fault_o  output  1 each  completion pulse / misaligned-or-illegal pulse.
REQ-012 wb_valid_o / wb_data_o  output  1 / DWIDTH  load result pulse and extended data.
REQ-013 dmem_req_o, dmem_we_o  output  1;  dmem_be_o  output  4;  dmem_addr_o  output  AWIDTH;  dmem_wdata_o  output  DWIDTH.
REQ-014 dmem_gnt_i, dmem_rvalid_i  input  1;  dmem_rdata_i  input  DWIDTH.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT.
REQ-016 accept = IDLE & ex_valid_i & (ex_memren_i | ex_memwren_i) & !done_o; memwren SHALL take precedence if both are set.
REQ-017 On accept, addr/wdata/funct3/we SHALL be captured into registers; nothing downstream SHALL depend on ex_* after accept.
REQ-018 Fault if: word access with addr[1:0]!=0; halfword with addr[0]!=0; load funct3 in {011,110,111}; store funct3 >= 011.
REQ-019 Faulting accept SHALL stay in IDLE, issue no dmem request, and pulse fault_o and done_o the next cycle.
REQ-020 Non-faulting accept SHALL move to REQ; dmem_req_o=1 throughout REQ with dmem_addr_o={addr[31:2],2'b00}, dmem_we_o, dmem_be_o, and dmem_wdata_o held stable until gnt.
REQ-021 In REQ, gnt with a store -> IDLE, done_o pulse the next cycle; gnt with a load -> WAIT; no gnt -> remain in REQ.
REQ-022 dmem_rvalid_i SHALL be ignored outside WAIT; in WAIT, rvalid -> IDLE, registered wb_data_o updated, wb_valid_o and done_o pulsed the next cycle.
REQ-023 Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{b[7:0]}}; SH be=4'b0011<<addr[1:0], wdata={2{h[15:0]}}; SW be=4'b1111; dmem_be_o=0 for loads.
REQ-024 Load extract: byte=rdata[8*addr[1:0]+:8], half=rdata[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-025 lsu_stall_o SHALL be combinational: 1 in the accept cycle, in REQ, and in WAIT; 0 otherwise, including the done_o cycle (upstream advances on that edge).
REQ-026 done_o, fault_o, and wb_valid_o SHALL be single-cycle pulses; wb_data_o SHALL hold its value until the next load completes.
REQ-027 ex_valid_i without a memory op SHALL produce no stall and no pulses.
REQ-028 Best-case latency: store accept->done_o is 2 cycles; load accept->wb_valid_o is 3 cycles.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE with every output 0, including dmem_req_o and wb_data_o.
REQ-030 Reset mid-REQ or mid-WAIT SHALL drop the captured op with no done_o; a late rvalid after release SHALL be ignored.
REQ-031 The first accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-032 SW addr=0x01000008, wdata=0xDEADBEEF, gnt same cycle as req -> be=1111, dmem_addr_o=0x01000008, done_o 2 cycles after accept, stall high 2 cycles.
REQ-033 SB addr=0x01000003, wdata=0x000000A5 -> be=1000, dmem_wdata_o=0xA5A5A5A5; gnt delayed 3 cycles -> req and addr stable for all 3 cycles.
REQ-034 rdata=0x80F0_7F81: LB @+0 -> 0xFFFFFF81; LBU @+0 -> 0x00000081; LH @+2 -> 0xFFFF80F0; LHU @+2 -> 0x000080F0; LW -> 0x80F07F81.
REQ-035 LW @0x01000002 and SH @0x01000001 -> fault_o and done_o pulse, dmem_req_o never asserted; load funct3=011 -> fault_o.
REQ-036 Assert rst in WAIT, then rvalid=1 after release -> no wb_valid_o, all outputs 0, next load completes normally.
REQ-037 Back-to-back loads with ex_valid_i held -> each op accepted exactly once, second accept in the cycle after done_o.
